// File: rtl/calc_mem_arbiter_if.sv
// calc_mem_arbiter_if: requester and memory-side bus of the shared operand/result memory arbiter
interface calc_mem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req0, rw0, gnt0, done0;
    logic              req1, rw1, gnt1, done1;
    logic [ADDR_W-1:0] addr0, addr1, mem_addr;
    logic [DATA_W-1:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
    logic              mem_en, mem_we, busy;

    modport slave (
        input  req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, mem_rdata,
        output gnt0, done0, gnt1, done1, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req0, rw0, addr0, wdata0, req1, rw1, addr1, wdata1, mem_rdata,
        input  gnt0, done0, gnt1, done1, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/calc_mem_arbiter.sv
// calc_mem_arbiter: round-robin sharing of the single-port operand/result memory between two ports
// ARB_FIXED_PRIO_EN: port 0 always wins simultaneous requests instead of round-robin
module calc_mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input logic               clk,
    input logic               reset,
    calc_mem_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]        state, state_n;
    logic              sel, rw_q, last_grant, both_sel, pick, any_req, active;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;

`ifdef ARB_FIXED_PRIO_EN
    assign both_sel = 1'b0;
`else
    assign both_sel = ~last_grant;
`endif

    assign any_req = bus.req0 | bus.req1;
    assign pick    = (bus.req0 && bus.req1) ? both_sel : bus.req1;

    always_comb
        state_n = (state == IDLE)   ? (any_req ? ACCESS : IDLE) :
                  (state == ACCESS) ? (rw_q ? DONE : RD_WAIT) :
                  (state == RD_WAIT) ? DONE : IDLE;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state      <= IDLE;
            sel        <= 1'b0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            last_grant <= 1'b1;
        end else begin
            state <= state_n;
            if (state == IDLE && any_req) begin
                sel     <= pick;
                rw_q    <= pick ? bus.rw1 : bus.rw0;
                addr_q  <= pick ? bus.addr1 : bus.addr0;
                wdata_q <= pick ? bus.wdata1 : bus.wdata0;
            end
            if (state == RD_WAIT)
                rdata_q <= bus.mem_rdata;
            if (state == DONE)
                last_grant <= sel;
        end

    // Memory-side signals are forced to zero outside ACCESS so the bus is quiet when idle
    assign active        = (state == ACCESS) || (state == RD_WAIT);
    assign bus.mem_en    = (state == ACCESS);
    assign bus.mem_we    = (state == ACCESS) && rw_q;
    assign bus.mem_addr  = (state == ACCESS) ? addr_q : '0;
    assign bus.mem_wdata = (state == ACCESS) ? wdata_q : '0;
    assign bus.gnt0      = active && !sel;
    assign bus.gnt1      = active && sel;
    assign bus.done0     = (state == DONE) && !sel;
    assign bus.done1     = (state == DONE) && sel;
    assign bus.busy      = (state != IDLE);
    assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_calc_mem_arbiter.sv
// tb_calc_mem_arbiter: randomized transaction-level check of calc_mem_arbiter against a memory model
module tb_calc_mem_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;
`ifdef ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    calc_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    calc_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    // Synchronous single-port memory that the arbiter drives
    logic [DW-1:0] mem [16];
    always @(posedge clk)
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else bus.mem_rdata <= mem[bus.mem_addr];
        end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level reference: pending requests, memory image, last served port
    logic          pend [2];
    logic          prw  [2];
    logic [AW-1:0] pa   [2];
    logic [DW-1:0] pd   [2];
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] ref_rdata;
    int            last;
    int            served;

    task automatic set_inputs();
        bus.req0 = pend[0]; bus.rw0 = prw[0]; bus.addr0 = pa[0]; bus.wdata0 = pd[0];
        bus.req1 = pend[1]; bus.rw1 = prw[1]; bus.addr1 = pa[1]; bus.wdata1 = pd[1];
    endtask

    task automatic post(input int p, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[p] = 1'b1; prw[p] = rw; pa[p] = a; pd[p] = d;
        set_inputs();
    endtask

    // Wait for the next completion and check it; keep=1 leaves the request raised afterwards
    task automatic run_txn(input bit keep);
        int exp_p, cyc, pre;
        logic e_rw;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_d;
        exp_p = (pend[0] && pend[1]) ? (FIXED ? 0 : 1 - last) : (pend[0] ? 0 : 1);
        e_rw = prw[exp_p]; e_a = pa[exp_p]; e_d = pd[exp_p];
        cyc = 0; pre = 0;
        do begin
            @(negedge clk);
            cyc++;
            check("excl", (bus.gnt0 & bus.gnt1) | (bus.done0 & bus.done1), 0);
            if (bus.mem_en) begin
                check("mem_addr", bus.mem_addr, e_a);
                check("mem_we", bus.mem_we, e_rw);
                if (e_rw) check("mem_wdata", bus.mem_wdata, e_d);
                check("gnt", {bus.gnt1, bus.gnt0}, exp_p ? 2 : 1);
                prw[exp_p] = 1'($urandom); pa[exp_p] = AW'($urandom); pd[exp_p] = DW'($urandom);
                set_inputs();
            end
            if (bus.busy && !bus.done0 && !bus.done1) pre++;
        end while (!(bus.done0 || bus.done1) && cyc < 12);
        if (!(bus.done0 || bus.done1)) begin
            check("timeout", 1, 0);
            return;
        end
        check("done_port", {bus.done1, bus.done0}, exp_p ? 2 : 1);
        check("latency", pre, e_rw ? 1 : 2);
        if (e_rw) ref_mem[e_a] = e_d;
        else ref_rdata = ref_mem[e_a];
        check("rdata", bus.rdata, ref_rdata);
        last = exp_p;
        served = exp_p;
        if (!keep) pend[exp_p] = 1'b0;
        set_inputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        pend[0] = 0; pend[1] = 0;
        set_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        last = 1;
        ref_rdata = '0;
    endtask

    initial begin
        int cyc;
        for (int p = 0; p < 2; p++) begin pend[p] = 0; prw[p] = 0; pa[p] = 0; pd[p] = 0; end
        set_inputs();
        last = 1;
        ref_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_outs", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.mem_en, bus.mem_we}, 0);
        check("rst_rdata", bus.rdata, 0);
        reset = 1'b0;

        // Fill the whole memory through random ports
        for (int a = 0; a < 16; a++) begin
            post(int'($urandom_range(0, 1)), 1'b1, AW'(a), DW'($urandom));
            run_txn(0);
        end

        // Port 0 write then read back
        post(0, 1'b1, 4'd3, 8'hA5); run_txn(0);
        post(0, 1'b0, 4'd3, 8'h00); run_txn(0);
        check("p0_rd_a5", bus.rdata, 8'hA5);

        // Port 1 write leaves rdata alone, then port 0 reads it
        post(1, 1'b1, 4'd2, 8'h3C); run_txn(0);
        check("wr_keeps_rdata", bus.rdata, 8'hA5);
        post(0, 1'b0, 4'd2, 8'h00); run_txn(0);
        check("p0_rd_3c", bus.rdata, 8'h3C);

        // Continuous contention from reset
        do_reset();
        post(0, 1'b0, 4'd1, 8'h00);
        post(1, 1'b0, 4'd4, 8'h00);
        for (int i = 0; i < 6; i++) begin
            run_txn(1);
            check("contend_seq", served, FIXED ? 0 : i % 2);
        end
        pend[0] = 0; pend[1] = 0; set_inputs();
        repeat (2) @(negedge clk);

        // Randomized rounds of one or two simultaneous requests
        for (int r = 0; r < 60; r++) begin
            for (int p = 0; p < 2; p++)
                if ($urandom_range(0, 1) == 1) post(p, 1'($urandom), AW'($urandom), DW'($urandom));
            if (!pend[0] && !pend[1]) post(int'($urandom_range(0, 1)), 1'($urandom), AW'($urandom), DW'($urandom));
            while (pend[0] || pend[1]) run_txn(0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset in RD_WAIT abandons the read; a fresh port 1 read then completes
        post(1, 1'b0, 4'd5, 8'h00);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!(bus.gnt1 && !bus.mem_en) && cyc < 10);
        check("reach_rd_wait", bus.gnt1 && !bus.mem_en, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_outs", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.mem_en, bus.mem_we}, 0);
        check("rst_mid_addr", bus.mem_addr, 0);
        check("rst_mid_rdata", bus.rdata, 0);
        repeat (2) begin
            @(negedge clk);
            check("rst_no_done", {bus.done0, bus.done1}, 0);
        end
        reset = 1'b0;
        last = 1;
        ref_rdata = '0;
        run_txn(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/calc_mem_arbiter.md
Name: calc_mem_arbiter

Overview:
- Shares the calculator's single-port operand/result memory between two requesters.
- Port 0 is the command read/write flow. Port 1 is the readout/serializer fetch path.
- Sequences every memory access (enable, write-enable, address, data) and returns read data with a done pulse.
- Round-robin arbitration gives both ports fair access.

Parameters:
ADDR_W, 4, memory address width
DATA_W, 8, memory data width

Ports:
clk  in  1  system clock
reset  in  1  async active-high reset
req0  in  1  port 0 request; held until done0
rw0  in  1  port 0 direction: 1=write, 0=read
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
gnt0  out  1  port 0 access in progress
done0  out  1  port 0 completion, 1-cycle pulse
req1  in  1  port 1 request; held until done1
rw1  in  1  port 1 direction
addr1  in  ADDR_W  port 1 address
wdata1  in  DATA_W  port 1 write data
gnt1  out  1  port 1 access in progress
done1  out  1  port 1 completion, 1-cycle pulse
rdata  out  DATA_W  read result; valid while done0/done1 high, then held
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid 1 cycle after mem_en with mem_we=0
busy  out  1  high in any state except IDLE

Behaviour:
- Clock/reset: clk is the clock. reset is asynchronous and active-high.
- Reset values: state=IDLE; last_grant=1 (port 0 favoured first); latched sel/rw/addr/wdata=0; rdata=0; all outputs 0.
- States:
  - IDLE: no memory activity.
  - ACCESS: mem_en=1; mem_we=latched rw; mem_addr and mem_wdata from latches; gnt of the selected port=1.
  - RD_WAIT: gnt of the selected port=1; capture mem_rdata into rdata.
  - DONE: done of the selected port=1 for exactly one cycle.
- busy=1 in ACCESS, RD_WAIT and DONE.
- IDLE transitions:
  - If any req is high, select a port and latch its rw/addr/wdata, then go to ACCESS.
  - Only one req high: that port wins.
  - Both high: the port not equal to last_grant wins.
- ACCESS transitions: rw=1 goes to DONE; rw=0 goes to RD_WAIT.
- RD_WAIT transition: DONE. rdata is updated on the RD_WAIT->DONE edge.
- DONE transition: update last_grant to the served port, then go to IDLE.
- Writes never modify rdata.
- Latency, with the request first seen in IDLE at cycle T:
  - Write: ACCESS at T+1, done at T+2.
  - Read: ACCESS at T+1, RD_WAIT at T+2, done with valid rdata at T+3.
- The minimum idle gap between accesses is 1 cycle (the IDLE state).
- Inputs change mid-access: rw/addr/wdata changes after latching are ignored.
- Request dropped mid-access: the access still completes and done still pulses; there is no abort.
- Request still high in IDLE after its done: it is treated as a new request, and round-robin then favours the other port if both are high.
- Simultaneous new requests in DONE: not sampled until IDLE.
- Reset mid-operation: the access is abandoned immediately, all outputs drop to 0, and no done pulse is issued.
- gnt0/gnt1 and done0/done1 are never high together.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- When defined: port 0 always wins a simultaneous request, and last_grant is ignored. Port 1 can starve under a continuous port 0 request.
- When undefined: round-robin as above.

Test Plan:
- Write then read on port 0: req0, rw0=1, addr0=3, wdata0=0xA5 gives mem_we=1 and mem_addr=3 at T+1 and done0 at T+2. Then rw0=0, addr0=3 gives done0 at T+3 with rdata=0xA5.
- Simultaneous requests from reset: req0 and req1 both reads in the same cycle; port 0 is served first, then port 1. Repeat with both high: port 0 is served first again, since last_grant=1 after serving port 1.
- Continuous contention: req0 and req1 held high for 6 accesses gives a strict alternating grant sequence 0,1,0,1,0,1. Under ARB_FIXED_PRIO_EN the sequence is 0,0,0,0,0,0.
- Address change during access: addr1 changes from 5 to 9 in the ACCESS cycle; mem_addr stays 5 and done1 is still issued.
- Reset mid-read: assert reset in RD_WAIT; all outputs are 0 immediately, there is no done pulse, and rdata=0. A fresh port 1 read after release completes in 3 cycles.
- Port 1 write followed by port 0 read: port 1 write addr=2, data=0x3C, then port 0 read addr=2 returns rdata=0x3C. rdata is unchanged by the write's done1.
